// File: rtl/btb_update_scheduler.sv
// BTB write sequencer: queued counter read-modify-write plus invalidate sweep.
// Ports: upd_* in / ready out, inv_req/busy, lookup_block, btb_r*/btb_w*, fifo_count.
// Optional stats outputs (stat_upd/alloc/sweep) when BTB_STATS_EN is defined.
module btb_update_scheduler #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i,
  output logic             upd_ready_o,
  input  logic             inv_req_i,
  output logic             inv_busy_o,
  output logic             lookup_block_o,
  output logic [IDX_W-1:0] btb_ridx_o,
  input  logic             btb_rvalid_i,
  input  logic [TAG_W-1:0] btb_rtag_i,
  input  logic [1:0]       btb_rctr_i,
  output logic             btb_we_o,
  output logic [IDX_W-1:0] btb_widx_o,
  output logic             btb_wvalid_o,
  output logic [TAG_W-1:0] btb_wtag_o,
  output logic [31:0]      btb_wtarget_o,
  output logic [1:0]       btb_wctr_o,
`ifdef BTB_STATS_EN
  output logic [15:0]      stat_upd_o,
  output logic [15:0]      stat_alloc_o,
  output logic [7:0]       stat_sweep_o,
`endif
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_SWEEP
  } state_t;

  state_t state;

  logic [IDX_W-1:0] q_idx [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];
  logic [31:0]      q_tgt [DEPTH];
  logic             q_tkn [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             inv_pend;
  logic             push;
  logic             pop;

  logic [IDX_W-1:0] head_idx;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      head_tgt;
  logic             head_tkn;
  logic             hit;
  logic             wr;
  logic [1:0]       ctr_nxt;

  logic unused_pc;
  assign unused_pc = ^upd_pc_i[1:0];

  assign inv_busy_o  = inv_pend | lookup_block_o;
  assign upd_ready_o = (fifo_count_o < FULL) & ~inv_busy_o;

  assign push = upd_valid_i & upd_ready_o;
  assign pop  = (state == S_WRITE);

  assign head_idx = q_idx[rd_ptr];
  assign head_tag = q_tag[rd_ptr];
  assign head_tgt = q_tgt[rd_ptr];
  assign head_tkn = q_tkn[rd_ptr];

  // btb_ridx_o points at the head during READ, so the
  // combinational read data belongs to the head entry.
  assign hit = btb_rvalid_i & (btb_rtag_i == head_tag);
  assign wr  = hit | head_tkn;

  always_comb begin
    ctr_nxt = btb_rctr_i;
    if (head_tkn && btb_rctr_i != 2'b11)
      ctr_nxt = btb_rctr_i + 2'b01;
    if (!head_tkn && btb_rctr_i != 2'b00)
      ctr_nxt = btb_rctr_i - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= upd_pc_i[IDX_W+1:2];
      q_tag[wr_ptr] <= upd_pc_i[31:32-TAG_W];
      q_tgt[wr_ptr] <= upd_target_i;
      q_tkn[wr_ptr] <= upd_taken_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count_o   <= '0;
      inv_pend       <= 1'b0;
      lookup_block_o <= 1'b0;
      btb_ridx_o     <= '0;
      btb_we_o       <= 1'b0;
      btb_widx_o     <= '0;
      btb_wvalid_o   <= 1'b0;
      btb_wtag_o     <= '0;
      btb_wtarget_o  <= '0;
      btb_wctr_o     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
        2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
        default: ;
      endcase
      // pulses during a sweep are absorbed
      if (inv_req_i && state != S_SWEEP)
        inv_pend <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (inv_pend) begin
            state          <= S_SWEEP;
            inv_pend       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count_o   <= '0;
            lookup_block_o <= 1'b1;
            btb_we_o       <= 1'b1;
            btb_widx_o     <= '0;
            btb_wvalid_o   <= 1'b0;
            btb_wtag_o     <= '0;
            btb_wtarget_o  <= '0;
            btb_wctr_o     <= '0;
          end else if (fifo_count_o != '0) begin
            state      <= S_READ;
            btb_ridx_o <= head_idx;
          end
        end
        S_READ: begin
          state         <= S_WRITE;
          btb_we_o      <= wr;
          btb_widx_o    <= head_idx;
          btb_wvalid_o  <= wr;
          btb_wtag_o    <= wr ? head_tag : '0;
          btb_wtarget_o <= wr ? head_tgt : '0;
          btb_wctr_o    <= !wr ? 2'b00 :
                           hit ? ctr_nxt : 2'b10;
        end
        S_WRITE: begin
          state         <= S_IDLE;
          btb_we_o      <= 1'b0;
          btb_widx_o    <= '0;
          btb_wvalid_o  <= 1'b0;
          btb_wtag_o    <= '0;
          btb_wtarget_o <= '0;
          btb_wctr_o    <= '0;
        end
        S_SWEEP: begin
          // btb_widx_o doubles as the sweep index
          if (btb_widx_o == '1) begin
            state          <= S_IDLE;
            lookup_block_o <= 1'b0;
            btb_we_o       <= 1'b0;
            btb_widx_o     <= '0;
          end else begin
            btb_widx_o <= btb_widx_o + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BTB_STATS_EN
  logic hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q        <= 1'b0;
      stat_upd_o   <= '0;
      stat_alloc_o <= '0;
      stat_sweep_o <= '0;
    end else begin
      if (state == S_READ)
        hit_q <= hit;
      if (state == S_WRITE && btb_we_o) begin
        if (hit_q) begin
          if (stat_upd_o != '1)
            stat_upd_o <= stat_upd_o + 1'b1;
        end else if (stat_alloc_o != '1) begin
          stat_alloc_o <= stat_alloc_o + 1'b1;
        end
      end
      if (state == S_SWEEP && btb_widx_o == '1 &&
          stat_sweep_o != '1)
        stat_sweep_o <= stat_sweep_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Scoreboard bench for btb_update_scheduler: BTB memory model, update
// reference model, directed cases then randomized traffic.
module tb_btb_update_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        upd_ready_o;
  logic        inv_req_i = 1'b0;
  logic        inv_busy_o;
  logic        lookup_block_o;
  logic [5:0]  btb_ridx_o;
  logic        btb_rvalid_i;
  logic [23:0] btb_rtag_i;
  logic [1:0]  btb_rctr_i;
  logic        btb_we_o;
  logic [5:0]  btb_widx_o;
  logic        btb_wvalid_o;
  logic [23:0] btb_wtag_o;
  logic [31:0] btb_wtarget_o;
  logic [1:0]  btb_wctr_o;
  logic [2:0]  fifo_count_o;

  btb_update_scheduler #(.IDX_W(6), .TAG_W(24), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i),
    .upd_ready_o(upd_ready_o), .inv_req_i(inv_req_i),
    .inv_busy_o(inv_busy_o), .lookup_block_o(lookup_block_o),
    .btb_ridx_o(btb_ridx_o), .btb_rvalid_i(btb_rvalid_i),
    .btb_rtag_i(btb_rtag_i), .btb_rctr_i(btb_rctr_i),
    .btb_we_o(btb_we_o), .btb_widx_o(btb_widx_o),
    .btb_wvalid_o(btb_wvalid_o), .btb_wtag_o(btb_wtag_o),
    .btb_wtarget_o(btb_wtarget_o), .btb_wctr_o(btb_wctr_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BTB storage seen by the DUT (combinational read)
  logic        mv   [64];
  logic [23:0] mtag [64];
  logic [31:0] mtgt [64];
  logic [1:0]  mctr [64];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        mv[i] <= 1'b0; mtag[i] <= '0; mtgt[i] <= '0; mctr[i] <= '0;
      end
    end else if (btb_we_o) begin
      mv[btb_widx_o]   <= btb_wvalid_o;
      mtag[btb_widx_o] <= btb_wtag_o;
      mtgt[btb_widx_o] <= btb_wtarget_o;
      mctr[btb_widx_o] <= btb_wctr_o;
    end
  end

  assign btb_rvalid_i = mv[btb_ridx_o];
  assign btb_rtag_i   = mtag[btb_ridx_o];
  assign btb_rctr_i   = mctr[btb_ridx_o];

  // reference model: accepted updates and the table they should build
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tkn;
  } upd_t;

  upd_t        q[$];
  bit          rv   [64];
  int          rtag [64];
  logic [31:0] rtgt [64];
  int          rctr [64];

  function automatic void mdl_clear();
    for (int i = 0; i < 64; i++) begin
      rv[i] = 0; rtag[i] = 0; rtgt[i] = '0; rctr[i] = 0;
    end
  endfunction

  // next update that must produce a write; no-write updates are consumed
  function automatic bit mdl_next(output logic [64:0] w);
    upd_t u;
    int i;
    int t;
    int c;
    w = '0;
    while (q.size() > 0) begin
      u = q.pop_front();
      i = int'(u.pc[7:2]);
      t = int'(u.pc[31:8]);
      if (rv[i] && rtag[i] == t) begin
        c = rctr[i] + (u.tkn ? 1 : -1);
        if (c > 3) c = 3;
        if (c < 0) c = 0;
      end else if (u.tkn) begin
        c = 2;
      end else begin
        continue;
      end
      rv[i] = 1; rtag[i] = t; rtgt[i] = u.tgt; rctr[i] = c;
      w = {1'b1, 6'(i), 24'(t), u.tgt, 2'(c)};
      return 1;
    end
    return 0;
  endfunction

  int   sweep_k = 0;
  int   sweeps_done = 0;
  int   upd_writes = 0;
  int   last_ctr = -1;
  bit   prev_lb = 0;
  bit   saw_full = 0;

  // monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    logic [64:0] act;
    logic [64:0] exp;
    bit ok;
    if (!rst_n) begin
      q.delete();
      mdl_clear();
      sweep_k = 0;
      prev_lb = 0;
    end else begin
      act = {btb_wvalid_o, btb_widx_o, btb_wtag_o,
             btb_wtarget_o, btb_wctr_o};
      if (btb_we_o) begin
        if (lookup_block_o) begin
          if (sweep_k == 0) begin
            q.delete();
            mdl_clear();
          end
          exp = {1'b0, 6'(sweep_k), 24'h0, 32'h0, 2'b00};
          chk("sweep_write", 96'(act), 96'(exp));
          sweep_k++;
        end else begin
          ok = mdl_next(exp);
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL unexpected_write: got %0h expected none", act);
          end else if (act !== exp) begin
            fails++;
            $display("FAIL upd_write: got %0h expected %0h", act, exp);
          end
          upd_writes++;
          last_ctr = int'(btb_wctr_o);
        end
      end
      if (lookup_block_o)
        chk("busy_in_sweep", 96'(inv_busy_o), 96'(1));
      if (prev_lb && !lookup_block_o) begin
        chk("sweep_len", 96'(sweep_k), 96'(64));
        chk("busy_fall", 96'(inv_busy_o), 96'(0));
        sweeps_done++;
        sweep_k = 0;
      end
      chk("ready_rule", 96'(upd_ready_o),
          96'((fifo_count_o < 3'(DEPTH)) && !inv_busy_o));
      if (fifo_count_o == 3'(DEPTH) && !upd_ready_o && !inv_busy_o)
        saw_full = 1;
      prev_lb = lookup_block_o;
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic tkn);
    int guard = 0;
    upd_valid_i = 1'b0;
    while (!upd_ready_o) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        tests++; fails++;
        $display("FAIL push_timeout: got ready=0 required ready=1");
        return;
      end
    end
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_taken_i  = tkn;
    q.push_back('{pc, tgt, tkn});
    @(negedge clk);
    upd_valid_i = 1'b0;
  endtask

  task automatic inv_pulse();
    upd_valid_i = 1'b0;
    inv_req_i = 1'b1;
    @(negedge clk);
    inv_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int guard = 0;
    while (quiet < 4) begin
      @(negedge clk);
      guard++;
      if (fifo_count_o == 0 && !inv_busy_o && !btb_we_o) quiet++;
      else quiet = 0;
      if (guard > 1000) begin
        tests++; fails++;
        $display("FAIL idle_timeout: got count=%0d busy=%0b required idle",
                 fifo_count_o, inv_busy_o);
        return;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] tg;
    logic [5:0]  ix;
    tg = ($urandom_range(0, 1) == 0) ? 24'h000001 : 24'h00abcd;
    ix = 6'($urandom_range(0, 7));
    return {tg, ix, 2'b00};
  endfunction

  initial begin
    int w0;
    int s0;
    int guard;
    logic [64:0] rem;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 96'(upd_ready_o), 96'(1));
    chk("rst_we", 96'(btb_we_o), 96'(0));
    chk("rst_count", 96'(fifo_count_o), 96'(0));
    chk("rst_busy", 96'(inv_busy_o), 96'(0));
    chk("rst_block", 96'(lookup_block_o), 96'(0));
    chk("rst_ridx", 96'(btb_ridx_o), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // allocate on an empty table, 3-cycle latency
    push(32'h0000_0104, 32'h0000_0200, 1'b1);
    @(negedge clk);
    chk("t1_not_early", 96'(btb_we_o), 96'(0));
    @(negedge clk);
    chk("t1_we", 96'(btb_we_o), 96'(1));
    chk("t1_write",
        96'({btb_wvalid_o, btb_widx_o, btb_wtag_o, btb_wtarget_o, btb_wctr_o}),
        96'({1'b1, 6'd1, 24'h000001, 32'h200, 2'd2}));
    wait_idle();

    // decrement to zero and saturate
    push(32'h0000_0104, 32'h0000_0200, 1'b0);
    wait_idle();
    chk("t2_ctr1", 96'(last_ctr), 96'(1));
    push(32'h0000_0104, 32'h0000_0200, 1'b0);
    wait_idle();
    chk("t2_ctr0", 96'(last_ctr), 96'(0));
    push(32'h0000_0104, 32'h0000_0200, 1'b0);
    wait_idle();
    chk("t2_sat0", 96'(last_ctr), 96'(0));

    // not-taken miss: no allocation
    w0 = upd_writes;
    push(32'h0000_0208, 32'h0000_0400, 1'b0);
    wait_idle();
    chk("t3_no_write", 96'(upd_writes), 96'(w0));
    chk("t3_count", 96'(fifo_count_o), 96'(0));

    // back-to-back pushes fill the FIFO
    w0 = upd_writes;
    saw_full = 0;
    for (int i = 0; i < 6; i++)
      push({24'h000012, 6'(10 + i), 2'b00}, 32'h1000 + 32'(i), 1'b1);
    wait_idle();
    chk("t4_full_seen", 96'(saw_full), 96'(1));
    chk("t4_writes", 96'(upd_writes), 96'(w0 + 6));

    // invalidate while the head is in READ, one more queued
    w0 = upd_writes;
    s0 = sweeps_done;
    push({24'h000033, 6'd20, 2'b00}, 32'h2000, 1'b1);
    push({24'h000033, 6'd21, 2'b00}, 32'h2004, 1'b1);
    inv_pulse();
    chk("t5_pending", 96'(inv_busy_o), 96'(1));
    chk("t5_not_blocked", 96'(lookup_block_o), 96'(0));
    wait_idle();
    chk("t5_one_write", 96'(upd_writes), 96'(w0 + 1));
    chk("t5_one_sweep", 96'(sweeps_done), 96'(s0 + 1));
    chk("t5_count", 96'(fifo_count_o), 96'(0));

    // reset in the middle of a sweep
    inv_pulse();
    guard = 0;
    while (!(lookup_block_o && btb_we_o && btb_widx_o == 6'd30)) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        tests++; fails++;
        $display("FAIL sweep30_timeout: got idx=%0d required 30", btb_widx_o);
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("t6_we_async", 96'(btb_we_o), 96'(0));
    chk("t6_block_async", 96'(lookup_block_o), 96'(0));
    chk("t6_busy_async", 96'(inv_busy_o), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", 96'(upd_ready_o), 96'(1));
    chk("t6_count", 96'(fifo_count_o), 96'(0));
    chk("t6_we", 96'(btb_we_o), 96'(0));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)
        push(rand_pc(), $urandom, ($urandom_range(0, 99) < 60));
      else if (r < 74)
        inv_pulse();
      else
        @(negedge clk);
    end
    wait_idle();

    tests++;
    if (mdl_next(rem)) begin
      fails++;
      $display("FAIL missing_write: got none expected %0h", rem);
    end
    for (int i = 0; i < 64; i++)
      chk("final_table",
          96'({mv[i], mtag[i], mtgt[i], mctr[i]}),
          96'({rv[i], 24'(rtag[i]), rtgt[i], 2'(rctr[i])}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: got no finish required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
